// File: rtl/team_07_wb_stream_bridge_if.sv
// ---------------------------------------------------------------------------
// team_07_wb_stream_bridge_if
//   Signal bundle for the team_07 Wishbone/stream bridge.
//   Carries the Wishbone classic slave port (plus active-low chip select),
//   the level interrupt, the TX stream towards the core and the RX stream
//   coming back from the core.
//
//   slave  modport : the bridge's view (bus inputs in, ack/data/irq out,
//                    drives TX stream, accepts RX stream)
//   master modport : the bus master / core side view (test environment)
// ---------------------------------------------------------------------------
interface team_07_wb_stream_bridge_if #(
  parameter int unsigned DW = 32
);
  // Wishbone classic slave port
  logic          ncs;
  logic [31:0]   adr_i;
  logic [31:0]   dat_i;
  logic [3:0]    sel_i;
  logic          cyc_i;
  logic          stb_i;
  logic          we_i;
  logic          ack_o;
  logic [31:0]   dat_o;
  // Interrupt towards the management core
  logic          irq_o;
  // TX stream: bridge -> core
  logic [DW-1:0] tx_data_o;
  logic          tx_valid_o;
  logic          tx_ready_i;
  // RX stream: core -> bridge
  logic [DW-1:0] rx_data_i;
  logic          rx_valid_i;
  logic          rx_ready_o;

  modport slave (
    input  ncs, adr_i, dat_i, sel_i, cyc_i, stb_i, we_i,
    output ack_o, dat_o, irq_o,
    output tx_data_o, tx_valid_o,
    input  tx_ready_i,
    input  rx_data_i, rx_valid_i,
    output rx_ready_o
  );

  modport master (
    output ncs, adr_i, dat_i, sel_i, cyc_i, stb_i, we_i,
    input  ack_o, dat_o, irq_o,
    input  tx_data_o, tx_valid_o,
    output tx_ready_i,
    output rx_data_i, rx_valid_i,
    input  rx_ready_o
  );
endinterface

// File: rtl/team_07_wb_stream_bridge.sv
// ---------------------------------------------------------------------------
// team_07_wb_stream_bridge
//   Wishbone classic slave that bridges the management bus to the team_07
//   core. Bus writes to DATA are queued in a TX FIFO that is drained to the
//   core over a valid/ready stream; words from the core are queued in an RX
//   FIFO and popped by bus reads of DATA. STAT/CTRL/FLAG registers and a
//   level interrupt allow polling or interrupt-driven operation.
//
//   Register window (16 bytes at BASE_ADDR):
//     0x0 DATA  W: push to TX (full byte select only)  R: pop RX (0 + UNF if empty)
//     0x4 STAT  R: {16'b0, rx_cnt, tx_cnt}
//     0x8 CTRL  [0]EN [1]TX_IE [2]RX_IE, write bit 3 = FLUSH (self-clearing)
//     0xC FLAG  [0]OVF [1]UNF sticky, write-1-to-clear
//
// Ports
//   clk_i : clock
//   rst_i : asynchronous active-high reset
//   bus   : team_07_wb_stream_bridge_if.slave (Wishbone, irq, TX/RX streams)
// ---------------------------------------------------------------------------
module team_07_wb_stream_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned DW        = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  team_07_wb_stream_bridge_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [3:0]    OFF_DATA = 4'h0;
  localparam logic [3:0]    OFF_STAT = 4'h4;
  localparam logic [3:0]    OFF_CTRL = 4'h8;
  localparam logic [3:0]    OFF_FLAG = 4'hC;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  // Transaction captured at request time, consumed in the ack cycle
  logic          ack_q,  ack_d;
  logic [3:0]    off_q,  off_d;
  logic          we_q,   we_d;
  logic [3:0]    sel_q,  sel_d;
  logic [31:0]   wdat_q, wdat_d;

  // Control and sticky status
  logic          en_q,    en_d;
  logic          tx_ie_q, tx_ie_d;
  logic          rx_ie_q, rx_ie_d;
  logic          ovf_q,   ovf_d;
  logic          unf_q,   unf_d;
  logic          irq_q,   irq_d;

  // FIFO bookkeeping
  logic [AW-1:0] tx_wp_q,  tx_wp_d;
  logic [AW-1:0] tx_rp_q,  tx_rp_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [AW-1:0] rx_wp_q,  rx_wp_d;
  logic [AW-1:0] rx_rp_q,  rx_rp_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;

  // FIFO storage (contents are don't-care outside the valid window)
  logic [DW-1:0] tx_mem_q [DEPTH];
  logic [DW-1:0] rx_mem_q [DEPTH];

  // -------------------------------------------------------------------------
  // Combinational events
  // -------------------------------------------------------------------------
  logic          req_s;
  logic          tx_empty_s, tx_full_s;
  logic          rx_empty_s, rx_full_s;
  logic          data_wr_s, data_rd_s;
  logic          ctrl_wr_s, flag_wr_s, flush_s;
  logic          tx_push_s, tx_pop_s;
  logic          rx_push_s, rx_pop_s;
  logic          ovf_set_s, unf_set_s;
  logic [31:0]   rdata_s;
  logic [DW-1:0] tx_head_s;

  // Qualify a new bus request and latch what it asks for.
  // ack_q in the request term blocks back-to-back acks and prevents a request
  // held through its ack from being served twice.
  always_comb begin
    req_s = bus.cyc_i & bus.stb_i & ~bus.ncs & ~ack_q &
            (bus.adr_i[31:4] == BASE_ADDR[31:4]);
    ack_d = req_s;
    if (req_s) begin
      off_d  = bus.adr_i[3:0];
      we_d   = bus.we_i;
      sel_d  = bus.sel_i;
      wdat_d = bus.dat_i;
    end else begin
      off_d  = off_q;
      we_d   = we_q;
      sel_d  = sel_q;
      wdat_d = wdat_q;
    end
  end

  // Decode the acknowledged access and the stream handshakes into FIFO events.
  always_comb begin
    tx_empty_s = (tx_cnt_q == CNT_ZERO);
    tx_full_s  = (tx_cnt_q == CNT_FULL);
    rx_empty_s = (rx_cnt_q == CNT_ZERO);
    rx_full_s  = (rx_cnt_q == CNT_FULL);

    data_wr_s  = ack_q & we_q  & (off_q == OFF_DATA) & (sel_q == 4'hF);
    data_rd_s  = ack_q & ~we_q & (off_q == OFF_DATA);
    ctrl_wr_s  = ack_q & we_q  & (off_q == OFF_CTRL);
    flag_wr_s  = ack_q & we_q  & (off_q == OFF_FLAG);
    flush_s    = ctrl_wr_s & wdat_q[3];

    tx_pop_s   = en_q & ~tx_empty_s & bus.tx_ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    tx_push_s  = data_wr_s & (~tx_full_s | tx_pop_s);
    ovf_set_s  = data_wr_s & tx_full_s & ~tx_pop_s;

    rx_push_s  = bus.rx_valid_i & ~rx_full_s;
    // The emptiness check uses the current count: a word arriving from the
    // core in the same cycle is kept, not handed to this read.
    rx_pop_s   = data_rd_s & ~rx_empty_s;
    unf_set_s  = data_rd_s & rx_empty_s;
  end

  // Next pointers and counts; FLUSH overrides any stream activity.
  always_comb begin
    if (flush_s) begin
      tx_wp_d  = PTR_ZERO;
      tx_rp_d  = PTR_ZERO;
      tx_cnt_d = CNT_ZERO;
      rx_wp_d  = PTR_ZERO;
      rx_rp_d  = PTR_ZERO;
      rx_cnt_d = CNT_ZERO;
    end else begin
      tx_wp_d  = tx_wp_q + AW'(tx_push_s);
      tx_rp_d  = tx_rp_q + AW'(tx_pop_s);
      tx_cnt_d = tx_cnt_q + CW'(tx_push_s) - CW'(tx_pop_s);
      rx_wp_d  = rx_wp_q + AW'(rx_push_s);
      rx_rp_d  = rx_rp_q + AW'(rx_pop_s);
      rx_cnt_d = rx_cnt_q + CW'(rx_push_s) - CW'(rx_pop_s);
    end
  end

  // CTRL register update.
  always_comb begin
    if (ctrl_wr_s) begin
      en_d    = wdat_q[0];
      tx_ie_d = wdat_q[1];
      rx_ie_d = wdat_q[2];
    end else begin
      en_d    = en_q;
      tx_ie_d = tx_ie_q;
      rx_ie_d = rx_ie_q;
    end
  end

  // Sticky flags: a set event beats a write-1-to-clear in the same cycle.
  always_comb begin
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (flag_wr_s && wdat_q[0]) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    if (unf_set_s) begin
      unf_d = 1'b1;
    end else if (flag_wr_s && wdat_q[1]) begin
      unf_d = 1'b0;
    end else begin
      unf_d = unf_q;
    end
  end

  // Interrupt is evaluated on the post-update state so it follows the FIFO
  // levels with exactly one register stage.
  always_comb begin
    irq_d = (tx_ie_d & (tx_cnt_d == CNT_ZERO)) |
            (rx_ie_d & (rx_cnt_d != CNT_ZERO));
  end

  // Read data mux, only driven during the ack cycle of a read.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (ack_q && !we_q) begin
      case (off_q)
        OFF_DATA: begin
          if (!rx_empty_s) begin
            rdata_s = 32'(rx_mem_q[rx_rp_q]);
          end else begin
            rdata_s = 32'h0000_0000;
          end
        end
        OFF_STAT: rdata_s = {16'h0000, 8'(rx_cnt_q), 8'(tx_cnt_q)};
        OFF_CTRL: rdata_s = {29'h0000_0000, rx_ie_q, tx_ie_q, en_q};
        OFF_FLAG: rdata_s = {30'h0000_0000, unf_q, ovf_q};
        default:  rdata_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  // TX head presented to the core, forced to zero when nothing is queued.
  always_comb begin
    if (tx_empty_s) begin
      tx_head_s = {DW{1'b0}};
    end else begin
      tx_head_s = tx_mem_q[tx_rp_q];
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // Control, status and FIFO pointer state with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q    <= 1'b0;
      off_q    <= 4'h0;
      we_q     <= 1'b0;
      sel_q    <= 4'h0;
      wdat_q   <= 32'h0000_0000;
      en_q     <= 1'b0;
      tx_ie_q  <= 1'b0;
      rx_ie_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      irq_q    <= 1'b0;
      tx_wp_q  <= PTR_ZERO;
      tx_rp_q  <= PTR_ZERO;
      tx_cnt_q <= CNT_ZERO;
      rx_wp_q  <= PTR_ZERO;
      rx_rp_q  <= PTR_ZERO;
      rx_cnt_q <= CNT_ZERO;
    end else begin
      ack_q    <= ack_d;
      off_q    <= off_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      wdat_q   <= wdat_d;
      en_q     <= en_d;
      tx_ie_q  <= tx_ie_d;
      rx_ie_q  <= rx_ie_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      irq_q    <= irq_d;
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      rx_cnt_q <= rx_cnt_d;
    end
  end

  // FIFO storage writes; no reset needed since the counts gate every read.
  always_ff @(posedge clk_i) begin
    if (tx_push_s) begin
      tx_mem_q[tx_wp_q] <= wdat_q[DW-1:0];
    end
    if (rx_push_s) begin
      rx_mem_q[rx_wp_q] <= bus.rx_data_i;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.ack_o      = ack_q;
  assign bus.dat_o      = rdata_s;
  assign bus.irq_o      = irq_q;
  assign bus.tx_valid_o = en_q & ~tx_empty_s;
  assign bus.tx_data_o  = tx_head_s;
  assign bus.rx_ready_o = ~rx_full_s;

endmodule

// File: tb/tb_team_07_wb_stream_bridge.sv
// ---------------------------------------------------------------------------
// tb_team_07_wb_stream_bridge
//   Self-checking bench for team_07_wb_stream_bridge. A queue-based model of
//   the bridge is advanced on every clock edge and compared with all DUT
//   outputs on every falling edge; directed sequences add literal checks.
// ---------------------------------------------------------------------------
module tb_team_07_wb_stream_bridge;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned DW    = 32;
  localparam logic [31:0] BASE  = 32'h3000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  team_07_wb_stream_bridge_if #(.DW(DW)) bus ();

  team_07_wb_stream_bridge #(
    .BASE_ADDR (BASE),
    .DEPTH     (DEPTH),
    .DW        (DW)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  bit bus_done = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ model state
  logic [31:0] tx_q[$];
  logic [31:0] rx_q[$];
  bit          m_en, m_txie, m_rxie, m_ovf, m_unf, m_irq, m_ack, m_we;
  logic [3:0]  m_off = 4'h0;
  logic [3:0]  m_sel = 4'h0;
  logic [31:0] m_dat = 32'h0;

  // Model: advance one clock according to the register map and FIFO rules.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        tx_q.delete(); rx_q.delete();
        m_en = 0; m_txie = 0; m_rxie = 0; m_ovf = 0; m_unf = 0;
        m_irq = 0; m_ack = 0; m_we = 0;
      end else begin
        bit pop_tx, push_rx, flush, req;
        logic [31:0] rxw;
        pop_tx  = m_en && (tx_q.size() > 0) && (bus.tx_ready_i === 1'b1);
        push_rx = (bus.rx_valid_i === 1'b1) && (rx_q.size() < DEPTH);
        rxw     = bus.rx_data_i;
        flush   = 0;
        req     = bus.cyc_i && bus.stb_i && !bus.ncs && !m_ack &&
                  (bus.adr_i[31:4] == BASE[31:4]);
        if (pop_tx) void'(tx_q.pop_front());
        if (m_ack) begin
          if (m_we) begin
            case (m_off)
              4'h0: if (m_sel == 4'hF) begin
                      if (tx_q.size() < DEPTH) tx_q.push_back(m_dat);
                      else m_ovf = 1;
                    end
              4'h8: begin
                      m_en = m_dat[0]; m_txie = m_dat[1]; m_rxie = m_dat[2];
                      flush = m_dat[3];
                    end
              4'hC: begin
                      if (m_dat[0]) m_ovf = 0;
                      if (m_dat[1]) m_unf = 0;
                    end
              default: ;
            endcase
          end else if (m_off == 4'h0) begin
            if (rx_q.size() > 0) void'(rx_q.pop_front());
            else m_unf = 1;
          end
        end
        if (push_rx) rx_q.push_back(rxw);
        if (flush) begin tx_q.delete(); rx_q.delete(); end
        m_ack = req;
        if (req) begin
          m_off = bus.adr_i[3:0]; m_we = bus.we_i; m_sel = bus.sel_i; m_dat = bus.dat_i;
        end
        m_irq = (m_txie && tx_q.size() == 0) || (m_rxie && rx_q.size() > 0);
      end
    end
  end

  // Compare: every falling edge, all outputs against the model.
  initial begin
    forever begin
      logic [31:0] exp_rd;
      @(negedge clk);
      exp_rd = 32'h0;
      if (m_ack && !m_we) begin
        case (m_off)
          4'h0: exp_rd = (rx_q.size() > 0) ? rx_q[0] : 32'h0;
          4'h4: exp_rd = {16'h0, 8'(rx_q.size()), 8'(tx_q.size())};
          4'h8: exp_rd = {29'h0, m_rxie, m_txie, m_en};
          4'hC: exp_rd = {30'h0, m_unf, m_ovf};
          default: exp_rd = 32'h0;
        endcase
      end
      check("ack_o",      32'(bus.ack_o),      32'(m_ack));
      check("dat_o",      bus.dat_o,           exp_rd);
      check("irq_o",      32'(bus.irq_o),      32'(m_irq));
      check("tx_valid_o", 32'(bus.tx_valid_o), 32'(m_en && tx_q.size() > 0));
      check("tx_data_o",  bus.tx_data_o,       (tx_q.size() > 0) ? tx_q[0] : 32'h0);
      check("rx_ready_o", 32'(bus.rx_ready_o), 32'(rx_q.size() < DEPTH));
    end
  end

  // ------------------------------------------------------------ bus tasks
  // Called just after a rising edge; returns just after the rising edge that
  // ends the ack cycle (or after a bounded wait when no ack is expected).
  task automatic wb(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                    input logic [3:0] sel, input bit exp_ack, input bit rdy_pulse,
                    output logic [31:0] rdat);
    bit got = 1'b0;
    rdat = 32'h0;
    bus.adr_i = adr; bus.dat_i = dat; bus.sel_i = sel; bus.we_i = we;
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (bus.ack_o === 1'b1) begin
        got  = 1'b1;
        rdat = bus.dat_o;
        if (rdy_pulse) bus.tx_ready_i = 1'b1;
      end
    end
    @(posedge clk); #1;
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
    if (rdy_pulse) bus.tx_ready_i = 1'b0;
    checks++;
    if (got != exp_ack) begin
      failures++;
      $display("FAIL wb_ack adr=%h: got ack=%0d expected ack=%0d", adr, got, exp_ack);
    end
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d);
    logic [31:0] r;
    wb(1'b1, BASE + 32'(off), d, 4'hF, 1'b1, 1'b0, r);
  endtask

  task automatic rd_chk(input string nm, input logic [3:0] off, input logic [31:0] exp);
    logic [31:0] r;
    wb(1'b0, BASE + 32'(off), 32'h0, 4'hF, 1'b1, 1'b0, r);
    check(nm, r, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  // ------------------------------------------------------------ stimulus
  initial begin
    logic [31:0] r;
    bus.ncs = 1'b0; bus.adr_i = 32'h0; bus.dat_i = 32'h0; bus.sel_i = 4'h0;
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
    bus.tx_ready_i = 1'b0; bus.rx_data_i = 32'h0; bus.rx_valid_i = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_rx_ready", 32'(bus.rx_ready_o), 32'h1);
    check("rst_tx_valid", 32'(bus.tx_valid_o), 32'h0);
    rd_chk("rst_stat", 4'h4, 32'h0);

    // T2: fill TX with EN=0, overflow, then drain in order
    for (int i = 1; i <= 8; i++) wr(4'h0, 32'hA5A5_0000 + 32'(i));
    rd_chk("t2_stat_full", 4'h4, 32'h0000_0008);
    check("t2_tx_valid_en0", 32'(bus.tx_valid_o), 32'h0);
    wr(4'h0, 32'hA5A5_0009);
    rd_chk("t2_flag_ovf", 4'hC, 32'h1);
    wr(4'hC, 32'h3);
    bus.tx_ready_i = 1'b1;
    wr(4'h8, 32'h1);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check("t2_drain_valid", 32'(bus.tx_valid_o), 32'h1);
      check("t2_drain_data", bus.tx_data_o, 32'hA5A5_0000 + 32'(i));
    end
    @(posedge clk); #1;
    bus.tx_ready_i = 1'b0;
    rd_chk("t2_stat_empty", 4'h4, 32'h0);

    // T3: three core words, read back, underflow, clear flags
    for (int i = 1; i <= 3; i++) begin
      bus.rx_valid_i = 1'b1; bus.rx_data_i = 32'h11 * 32'(i);
      @(posedge clk); #1;
    end
    bus.rx_valid_i = 1'b0;
    rd_chk("t3_stat", 4'h4, 32'h0000_0300);
    rd_chk("t3_rd1", 4'h0, 32'h11);
    rd_chk("t3_rd2", 4'h0, 32'h22);
    rd_chk("t3_rd3", 4'h0, 32'h33);
    rd_chk("t3_rd_empty", 4'h0, 32'h0);
    rd_chk("t3_flag_unf", 4'hC, 32'h2);
    wr(4'hC, 32'h3);
    rd_chk("t3_flag_clr", 4'hC, 32'h0);

    // T4: write to full TX in the same cycle as a pop; then flush
    wr(4'h8, 32'h1);
    for (int i = 0; i < 8; i++) wr(4'h0, 32'hB0 + 32'(i));
    wb(1'b1, BASE, 32'hBEEF, 4'hF, 1'b1, 1'b1, r);
    rd_chk("t4_stat", 4'h4, 32'h0000_0008);
    rd_chk("t4_flag", 4'hC, 32'h0);
    check("t4_head", bus.tx_data_o, 32'hB1);
    wr(4'h8, 32'h8);
    rd_chk("t4_stat_flush", 4'h4, 32'h0);
    rd_chk("t4_ctrl_flush", 4'h8, 32'h0);

    // T5: RX interrupt follows the RX level with one cycle of latency
    wr(4'h8, 32'h4);
    bus.rx_valid_i = 1'b1; bus.rx_data_i = 32'h55;
    @(negedge clk);
    check("t5_irq_before", 32'(bus.irq_o), 32'h0);
    @(posedge clk); #1;
    bus.rx_valid_i = 1'b0;
    @(negedge clk);
    check("t5_irq_set", 32'(bus.irq_o), 32'h1);
    @(posedge clk); #1;
    rd_chk("t5_rd", 4'h0, 32'h55);
    @(negedge clk);
    check("t5_irq_clr", 32'(bus.irq_o), 32'h0);
    @(posedge clk); #1;
    wr(4'h8, 32'h2);
    @(negedge clk);
    check("t5_irq_txie", 32'(bus.irq_o), 32'h1);
    @(posedge clk); #1;
    wr(4'h8, 32'h0);

    // T6: chip select, partial byte select, outside window, unmapped offset
    bus.ncs = 1'b1; bus.adr_i = BASE; bus.we_i = 1'b1; bus.sel_i = 4'hF;
    bus.dat_i = 32'hDEAD; bus.cyc_i = 1'b1; bus.stb_i = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("t6_ncs_noack", 32'(bus.ack_o), 32'h0);
    end
    @(posedge clk); #1;
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0; bus.ncs = 1'b0;
    wb(1'b1, BASE, 32'h1234, 4'h3, 1'b1, 1'b0, r);
    rd_chk("t6_stat_sel", 4'h4, 32'h0);
    wb(1'b0, BASE + 32'h10, 32'h0, 4'hF, 1'b0, 1'b0, r);
    rd_chk("t6_unmapped", 4'h2, 32'h0);

    // Randomized traffic against the model
    wr(4'h8, 32'h1);
    fork
      begin : bus_proc
        int k;
        logic [31:0] rr;
        for (int n = 0; n < 250; n++) begin
          k = $urandom_range(0, 11);
          case (k)
            0, 1, 2: wr(4'h0, $urandom);
            3:       wb(1'b1, BASE, $urandom, 4'($urandom_range(0, 15)), 1'b1, 1'b0, rr);
            4, 5, 6: wb(1'b0, BASE, 32'h0, 4'hF, 1'b1, 1'b0, rr);
            7:       wb(1'b0, BASE + 32'h4, 32'h0, 4'hF, 1'b1, 1'b0, rr);
            8:       wr(4'h8, {28'h0, ($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)),
                               ($urandom_range(0, 3) != 0)});
            9:       wb(1'b0, BASE + (($urandom_range(0, 1) == 0) ? 32'h8 : 32'hC),
                        32'h0, 4'hF, 1'b1, 1'b0, rr);
            10:      wr(4'hC, 32'($urandom_range(0, 3)));
            default: wb($urandom_range(0, 1) == 1, BASE + 32'($urandom_range(1, 7)),
                        $urandom, 4'hF, 1'b1, 1'b0, rr);
          endcase
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
        bus_done = 1'b1;
      end
      begin : stream_proc
        bit acc;
        while (!bus_done) begin
          @(negedge clk);
          acc = bus.rx_valid_i && bus.rx_ready_o;
          @(posedge clk); #1;
          bus.tx_ready_i = ($urandom_range(0, 1) == 1);
          if (!bus.rx_valid_i || acc) begin
            bus.rx_valid_i = ($urandom_range(0, 2) != 0);
            bus.rx_data_i  = $urandom;
          end
        end
        bus.rx_valid_i = 1'b0;
        bus.tx_ready_i = 1'b0;
      end
    join

    // T1: asynchronous reset in the middle of an acknowledged transaction
    @(posedge clk); #1;
    wr(4'h8, 32'h0);
    wr(4'h0, 32'h77);
    bus.adr_i = BASE + 32'h4; bus.we_i = 1'b0; bus.cyc_i = 1'b1; bus.stb_i = 1'b1;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("t1_ack",      32'(bus.ack_o),      32'h0);
    check("t1_dat",      bus.dat_o,           32'h0);
    check("t1_irq",      32'(bus.irq_o),      32'h0);
    check("t1_tx_valid", 32'(bus.tx_valid_o), 32'h0);
    check("t1_tx_data",  bus.tx_data_o,       32'h0);
    check("t1_rx_ready", 32'(bus.rx_ready_o), 32'h1);
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    rd_chk("t1_stat", 4'h4, 32'h0);
    rd_chk("t1_ctrl", 4'h8, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
